// File: rtl/pipe_intr_pkg.sv
// Shared definitions for the pipeline interrupt/hazard sequencer:
// FSM state encoding and the PC-mux select codes driven to the fetch stage.
package pipe_intr_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_HANDLER = 2'b01,
        ST_HOLD    = 2'b10
    } state_e;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_VEC = 2'b01;
    localparam logic [1:0] PC_EPC = 2'b10;

endpackage

// File: rtl/pipe_intr_ctrl_irq_sync.sv
// irq_sync: W-wide two-flop synchronizer for the asynchronous interrupt lines.
// Ports:
//   clk   in  1  clock, rising edge
//   clrn  in  1  asynchronous active-low reset (both stages cleared)
//   d_in  in  W  asynchronous level inputs
//   d_out out W  synchronized levels (second stage)
module irq_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_in;
            s2_q <= s1_q;
        end
    end

    assign d_out = s2_q;

endmodule

// File: rtl/pipe_intr_ctrl.sv
// pipe_intr_ctrl: interrupt/hazard sequencer for the 5-stage pipeline.
// Takes external interrupts (redirect to VEC_ADDR, cancel ID, record EPC/cause),
// handles eret return with a post-return holdoff, and load-use stalls.
// Optional build macro: INTR_MASK_EN adds a writable irq mask (mask_we/mask_din);
// without it the mask is fixed to all ones and those ports do not exist.
// Ports:
//   clk, clrn              clock / async active-low reset
//   irq                    level interrupt requests (asynchronous)
//   id_valid, id_pc        ID stage instruction valid and its PC
//   id_eret, ld_use_hz     ID instruction is eret / load-use hazard on ID
//   mask_we, mask_din      mask write (INTR_MASK_EN only)
//   stall, if_flush        freeze PC + IF/ID / zero IF/ID on next edge
//   id_exe_bubble          zero ID/EXE control bits on next edge
//   pc_sel, redirect_pc    PC mux select and redirect target
//   epc, cause, status_ie  saved return PC, accepted line, interrupts enabled
//
// state   | meaning
// RUN     | normal execution, interrupts may be accepted
// HANDLER | inside handler, interrupts off, waiting for eret
// HOLD    | post-return fetch window, hold_cnt non-stalled cycles before RUN
module pipe_intr_ctrl
    import pipe_intr_pkg::*;
#(
    parameter int          NUM_IRQ  = 4,
    parameter logic [31:0] VEC_ADDR = 32'h0000_0008,
    parameter int          HOLDOFF  = 2,
    localparam int         CW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               id_valid,
    input  logic [31:0]        id_pc,
    input  logic               id_eret,
    input  logic               ld_use_hz,
`ifdef INTR_MASK_EN
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_din,
`endif
    output logic               stall,
    output logic               if_flush,
    output logic               id_exe_bubble,
    output logic [1:0]         pc_sel,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        epc,
    output logic [CW-1:0]      cause,
    output logic               status_ie
);

    localparam int HW = $clog2(HOLDOFF + 1);

    state_e               state_q, state_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [31:0]          epc_q, epc_d;
    logic [CW-1:0]        cause_q, cause_d;
    logic [NUM_IRQ-1:0]   irq_s2;
    logic [NUM_IRQ-1:0]   mask;
    logic [NUM_IRQ-1:0]   pend;
    logic [CW-1:0]        low_idx;
    logic                 take_eret;
    logic                 accept;

    irq_sync #(.W(NUM_IRQ)) u_irq_sync (
        .clk   (clk),
        .clrn  (clrn),
        .d_in  (irq),
        .d_out (irq_s2)
    );

`ifdef INTR_MASK_EN
    logic [NUM_IRQ-1:0] mask_q, mask_d;

    // A write lands on the edge, so an accept in the same cycle still sees the old mask.
    always_comb begin
        mask_d = mask_we ? mask_din : mask_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) mask_q <= '1;
        else       mask_q <= mask_d;
    end

    assign mask = mask_q;
`else
    assign mask = '1;
`endif

    assign pend = irq_s2 & mask;

    // Lowest-numbered pending line wins: scan downwards so the last hit is the lowest.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) low_idx = CW'(i);
        end
    end

    // Priority: load-use hazard > eret > interrupt.
    assign take_eret = ~ld_use_hz & (state_q == ST_HANDLER) & id_eret;
    assign accept    = ~ld_use_hz & (state_q == ST_RUN) & (|pend) & id_valid
                       & ~id_eret & (hold_cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        stall         = 1'b0;
        if_flush      = 1'b0;
        id_exe_bubble = 1'b0;
        pc_sel        = PC_SEQ;

        if (ld_use_hz) begin
            // Frozen cycle: HOLD does not count it as fetch progress.
            stall         = 1'b1;
            id_exe_bubble = 1'b1;
        end else if (take_eret) begin
            pc_sel        = PC_EPC;
            if_flush      = 1'b1;
            id_exe_bubble = 1'b1;
            state_d       = ST_HOLD;
            hold_cnt_d    = HW'(HOLDOFF);
        end else if (accept) begin
            pc_sel        = PC_VEC;
            if_flush      = 1'b1;
            id_exe_bubble = 1'b1;
            state_d       = ST_HANDLER;
            epc_d         = id_pc;
            cause_d       = low_idx;
        end else if (state_q == ST_HOLD) begin
            if (hold_cnt_q <= HW'(1)) begin
                state_d    = ST_RUN;
                hold_cnt_d = '0;
            end else begin
                hold_cnt_d = hold_cnt_q - HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= '0;
            epc_q      <= '0;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        case (pc_sel)
            PC_VEC:  redirect_pc = VEC_ADDR;
            PC_EPC:  redirect_pc = epc_q;
            default: redirect_pc = '0;
        endcase
    end

    assign epc       = epc_q;
    assign cause     = cause_q;
    assign status_ie = (state_q != ST_HANDLER);

endmodule
